stream_fifo: RTL
================

Name: stream_fifo

Overview:
- Valid/ready FIFO buffer that sits directly downstream of stream_delay.
- Absorbs the randomized stalls stream_delay inserts, so the consumer sees a smoothed, ordered stream.
- Generic payload type; optional fall-through mode for zero-latency pass-through when empty.
- Used in benches and RTL wherever a decoupling buffer is needed between handshake stages.

Parameters:
- FallThrough, 1'b0: 1 = an empty FIFO forwards input combinationally to output in the same cycle.
- Depth, 8: number of storage entries; must be >= 1; non-power-of-two allowed.
- payload_t, logic: type parameter carried per entry.
- UsageWidth, $clog2(Depth+1): derived; width of usage_o; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear; discards all stored entries.
- payload_i  in  payload_t  input data.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- payload_o  out  payload_t  output data.
- valid_o  out  1  output valid.
- ready_i  in  1  output ready.
- usage_o  out  UsageWidth  number of stored entries.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - rd/wr pointers = 0, usage = 0.
  - valid_o = 0, ready_o = 1, usage_o = 0.
  - Storage array is not reset; payload_o is don't-care while valid_o = 0.
- Handshake:
  - push = valid_i && ready_o; pop = valid_o && ready_i. Both are evaluated at the rising edge.
  - ready_o = (usage != Depth). It never depends on ready_i, so there is no combinational ready path.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - valid_o does not depend combinationally on ready_i.
  - Upstream must hold payload_i stable while valid_i && !ready_o (AXI rule); the block does not check this.
- Latency, FallThrough = 0:
  - An entry pushed at edge N is visible on valid_o/payload_o after edge N (1-cycle latency).
  - payload_o = mem[rd_ptr]; valid_o = (usage != 0).
- Latency, FallThrough = 1, when usage == 0:
  - valid_o = valid_i and payload_o = payload_i, combinationally.
  - If ready_i is also high, the item passes through: not stored, usage stays 0.
  - If ready_i is low, the item is stored normally.
- Counter and pointer updates:
  - usage +1 on push only, -1 on pop only, unchanged on push && pop.
  - Pointers increment on their event and wrap from Depth-1 to 0. There is no power-of-two assumption; wrap is an explicit compare.
- Flush:
  - flush_i high at edge N sets pointers and usage to 0 after edge N.
  - A push or pop in the same cycle is discarded; ready_o still shows its normal value.
  - valid_o = 0 the cycle after the flush (FallThrough=1 may re-assert it combinationally from valid_i).
- Reset mid-operation: asynchronous; contents are dropped immediately and outputs take their reset values.
- Elaboration: Depth == 0 is a fatal error.
- Assertions (simulation only):
  - no push while full;
  - no pop while empty (non-FT);
  - usage_o <= Depth.

Decomposition:
- No shared package: all types come from payload_t and the derived UsageWidth.
- One natural sub-module, stream_fifo_mem: Depth x payload_t register array, single write port, asynchronous read by index, no reset.
- Pointer, usage and handshake logic stay in stream_fifo.

Test Plan:
- Reset: hold rst_ni = 0 for 3 cycles -> valid_o = 0, ready_o = 1, usage_o = 0 throughout and the cycle after release.
- Fill/drain, Depth=4, payload_t=int, ready_i=0:
  - push 1,2,3,4 -> usage_o 1..4, ready_o = 0 after the 4th edge; item 5 is held upstream.
  - then ready_i = 1 -> payload_o reads 1,2,3,4,5 in order, and usage_o returns to 0.
- Steady state at usage 2: push and pop every cycle for 10 cycles -> usage_o constant 2, output order matches input order.
- Wrap, Depth=3:
  - stream_delay (StallRandom=1) upstream, random ready_i downstream, 10000 incrementing ints.
  - -> output sequence is exactly 0..9999 with no gaps or duplicates; ready_o never high while usage_o == 3.
- Flush at usage_o = 3 with valid_i = 1, payload 0xAA -> after the edge usage_o = 0, valid_o = 0, and 0xAA never appears on the output.
- Fall-through, FallThrough=1, empty:
  - valid_i = 1, payload 0x55, ready_i = 1 -> valid_o = 1 and payload_o = 0x55 in the same cycle, usage_o stays 0.
  - same input with ready_i = 0 -> usage_o = 1.

Source files
------------

// File: rtl/stream_fifo_mem.sv
// Register-array storage for stream_fifo: Depth entries of payload_t,
// one synchronous write port and an asynchronous read by index.
// Contents are deliberately not reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - read data (combinational from raddr)
module stream_fifo_mem #(
    parameter int unsigned Depth     = 8,
    parameter type         payload_t = logic,
    parameter int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  payload_t             wdata,
    input  logic [AddrWidth-1:0] raddr,
    output payload_t             rdata
);

    payload_t mem_q [Depth];

    // Write port; no reset on storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO decoupling buffer with optional fall-through when empty.
// Ports:
//   clk_i, rst_ni        - clock (rising edge), async active-low reset
//   flush_i              - synchronous clear of all stored entries
//   payload_i, valid_i   - upstream data/valid
//   ready_o              - upstream ready (high whenever not full)
//   payload_o, valid_o   - downstream data/valid
//   ready_i              - downstream ready
//   usage_o              - number of stored entries
module stream_fifo #(
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned Depth       = 8,
    parameter type         payload_t   = logic,
    parameter int unsigned UsageWidth  = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  payload_t              payload_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output payload_t              payload_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [UsageWidth-1:0] usage_o
);

    localparam int unsigned         PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastIdx   = PtrWidth'(Depth - 1);
    localparam logic [UsageWidth-1:0] FullCount = UsageWidth'(Depth);

    // Zero-entry FIFO is meaningless; stop at elaboration.
    if (Depth == 0) begin : g_depth_check
        $fatal(1, "stream_fifo: Depth must be >= 1");
    end

    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [UsageWidth-1:0] usage_q;
    logic                  empty;
    logic                  full;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  write_en;
    logic                  read_en;
    payload_t              mem_rdata;

    assign empty  = (usage_q == '0);
    assign full   = (usage_q == FullCount);
    assign bypass = FallThrough && empty;

    // Handshake; ready_o depends only on state, never on ready_i.
    assign ready_o   = !full;
    assign valid_o   = bypass ? valid_i : !empty;
    assign payload_o = bypass ? payload_i : mem_rdata;
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;

    // A bypassed item that is consumed in the same cycle is never stored;
    // a flush discards any concurrent push or pop.
    assign write_en = push && !(bypass && ready_i) && !flush_i;
    assign read_en  = pop && !bypass && !flush_i;

    assign usage_o = usage_q;

    // Pointers and occupancy; wrap is an explicit compare (no 2^n assumption).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (read_en) begin
                rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({write_en, read_en})
                2'b10:   usage_q <= usage_q + UsageWidth'(1);
                2'b01:   usage_q <= usage_q - UsageWidth'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

    stream_fifo_mem #(
        .Depth     (Depth),
        .payload_t (payload_t),
        .AddrWidth (PtrWidth)
    ) u_mem (
        .clk   (clk_i),
        .we    (write_en),
        .waddr (wr_ptr_q),
        .wdata (payload_i),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(write_en && full))
        else $error("stream_fifo: write while full");

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(read_en && empty))
        else $error("stream_fifo: read while empty");

    a_usage_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        usage_q <= FullCount)
        else $error("stream_fifo: usage above depth");
`endif

endmodule
